// File: rtl/qam_frame_sched.sv
// Symbol scheduler for the 16-QAM modulator. Each frame is a fixed preamble,
// then payload nibbles (low nibble first), then idle slots counted at carrier instants.
module qam_frame_sched #(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter logic [3:0]  PREAMBLE_SYM = 4'b0101,
  parameter int unsigned GAP_LEN      = 4,
  parameter int unsigned UNDERRUN_TO  = 64
) (
  input  logic       axi_clk,
  input  logic       axi_rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [3:0] sym_data,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAY_LO,
    ST_PAY_HI,
    ST_GAP
  } state_t;

  localparam logic [7:0] PRE_LAST   = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_LEN - 1);
  localparam logic [7:0] STARVE_MAX = 8'(UNDERRUN_TO - 1);

  state_t     state;
  logic [7:0] slot_cnt;    // preamble transfers, then gap ready slots
  logic [7:0] starve_cnt;
  logic [3:0] hold_nib;
  logic       hold_last;
  logic       aborted;
  logic       xfer;

  // The low nibble passes straight through from the byte stream so a byte
  // and its first symbol are handed over in the same carrier instant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    s_ready   = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 4'h0;
    unique case (state)
      ST_PREAMBLE: begin
        sym_valid = 1'b1;
        sym_data  = PREAMBLE_SYM;
      end
      ST_PAY_LO: begin
        sym_valid = s_valid;
        sym_data  = s_data[3:0];
        s_ready   = sym_ready;
      end
      ST_PAY_HI: begin
        sym_valid = 1'b1;
        sym_data  = hold_nib;
      end
      default: ;
    endcase
  end

  assign xfer = sym_valid && sym_ready;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge axi_clk) begin
    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    if (axi_rst) begin
      state      <= ST_IDLE;
      slot_cnt   <= 8'd0;
      starve_cnt <= 8'd0;
      hold_nib   <= 4'h0;
      hold_last  <= 1'b0;
      aborted    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          slot_cnt <= 8'd0;
          aborted  <= 1'b0;
          if (s_valid) state <= ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (xfer) begin
            if (slot_cnt == PRE_LAST) begin
              slot_cnt   <= 8'd0;
              starve_cnt <= 8'd0;
              state      <= ST_PAY_LO;
            end else begin
              slot_cnt <= slot_cnt + 8'd1;
            end
          end
        end
        ST_PAY_LO: begin
          if (xfer) begin
            hold_nib   <= s_data[7:4];
            hold_last  <= s_last;
            starve_cnt <= 8'd0;
            state      <= ST_PAY_HI;
          end else if (s_valid) begin
            starve_cnt <= 8'd0;
          end else if (starve_cnt == STARVE_MAX) begin
            // Source went quiet mid-frame: close it out through the gap without frame_done.
            starve_cnt <= 8'd0;
            slot_cnt   <= 8'd0;
            aborted    <= 1'b1;
            underrun   <= 1'b1;
            state      <= ST_GAP;
          end else begin
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        ST_PAY_HI: begin
          if (xfer) begin
            slot_cnt <= 8'd0;
            state    <= hold_last ? ST_GAP : ST_PAY_LO;
          end
        end
        ST_GAP: begin
          if (sym_ready) begin
            if (slot_cnt == GAP_LAST) begin
              slot_cnt   <= 8'd0;
              frame_done <= !aborted;
              state      <= ST_IDLE;
            end else begin
              slot_cnt <= slot_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_frame_sched.sv
// Self-checking bench for qam_frame_sched: randomized frames and carrier ready
// patterns checked against a queue-based model of the expected symbol stream.
`timescale 1ns/1ps
module tb_qam_frame_sched;

  localparam int         PRE_LEN = 8;
  localparam logic [3:0] PRE_SYM = 4'h5;
  localparam int         GAP     = 4;
  localparam int         URUN    = 64;

  logic       axi_clk = 1'b0;
  logic       axi_rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data  = 8'h00;
  logic       s_last  = 1'b0;
  logic       sym_valid;
  logic       sym_ready = 1'b0;
  logic [3:0] sym_data;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  qam_frame_sched #(
    .PREAMBLE_LEN(PRE_LEN),
    .PREAMBLE_SYM(PRE_SYM),
    .GAP_LEN     (GAP),
    .UNDERRUN_TO (URUN)
  ) dut (
    .axi_clk   (axi_clk),
    .axi_rst   (axi_rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  always #5 axi_clk = ~axi_clk;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;   // 0: always ready, 1: one cycle in four, 2: random
  int ready_cyc = 0;

  logic [3:0] exp_q[$];   // symbols the modulator must see, in order
  int         len_q[$];   // bytes each open frame must consume
  logic [7:0] fb[16];
  int exp_done = 0, exp_urun = 0, done_cnt = 0, urun_cnt = 0;
  int acc_frame = 0, gap_slots = 0, cyc = 0, last_xfer_cyc = 0;
  logic       prev_stall = 1'b0, prev_idle_sv = 1'b0, rst_prev = 1'b0;
  logic [3:0] prev_sym = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Carrier zero-crossing model.
  initial begin
    forever begin
      @(posedge axi_clk); #1;
      ready_cyc++;
      case (ready_mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = (ready_cyc % 4 == 0);
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge axi_clk);
      cyc++;
      if (rst_prev)
        check("rst_out", 32'({s_ready, sym_valid, sym_data, busy, frame_done, underrun}), 32'd0);
      if (axi_rst) begin
        prev_stall   = 1'b0;
        prev_idle_sv = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", 32'({sym_valid, sym_data}), 32'({1'b1, prev_sym}));
        if (prev_idle_sv)
          check("frame_start", 32'({sym_valid, sym_data}), 32'({1'b1, PRE_SYM}));
        if (!busy)
          check("idle_out", 32'({sym_valid, s_ready}), 32'd0);
        if (frame_done) begin
          done_cnt++;
          check("gap_slots", 32'(gap_slots), 32'(GAP));
          if (len_q.size() == 0) check("spurious_done", 32'(frame_done), 32'd0);
          else check("bytes_taken", 32'(acc_frame), 32'(len_q.pop_front()));
          acc_frame = 0;
        end
        if (underrun) begin
          urun_cnt++;
          check("underrun_time", 32'(cyc - last_xfer_cyc), 32'(URUN + 1));
          if (len_q.size() == 0) check("spurious_underrun", 32'(underrun), 32'd0);
          else check("bytes_taken", 32'(acc_frame), 32'(len_q.pop_front()));
          acc_frame = 0;
          gap_slots = 0;
        end
        if (sym_valid && sym_ready) begin
          if (exp_q.size() == 0) check("extra_sym", 32'(sym_data), 32'hffff_ffff);
          else begin
            e = exp_q.pop_front();
            check("sym", 32'(sym_data), 32'(e));
          end
          gap_slots     = 0;
          last_xfer_cyc = cyc;
        end else if (busy && !sym_valid && sym_ready) begin
          gap_slots++;
        end
        if (s_valid && s_ready) acc_frame++;
        prev_stall   = sym_valid && !sym_ready;
        prev_sym     = sym_data;
        prev_idle_sv = !busy && s_valid;
      end
      rst_prev = axi_rst;
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge axi_clk);
      n++;
    end while (!s_ready && n < 2000);
    if (!s_ready) begin
      check("accept_timeout", 32'(s_ready), 32'd1);
      finish_run();
    end
    @(posedge axi_clk); #1;
  endtask

  task automatic wait_underrun();
    int n = 0;
    do begin
      @(negedge axi_clk);
      n++;
    end while (!underrun && n < 500);
    if (!underrun) begin
      check("underrun_timeout", 32'(underrun), 32'd1);
      finish_run();
    end
    @(posedge axi_clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge axi_clk); #1;
      n++;
    end while (!(!busy && done_cnt + urun_cnt == exp_done + exp_urun) && n < 3000);
    if (busy || done_cnt + urun_cnt != exp_done + exp_urun) begin
      check("idle_timeout", 32'({busy, 16'(done_cnt + urun_cnt)}), 32'({1'b0, 16'(exp_done + exp_urun)}));
      finish_run();
    end
  endtask

  function automatic void expect_frame(input int nbytes);
    for (int k = 0; k < PRE_LEN; k++) exp_q.push_back(PRE_SYM);
    for (int i = 0; i < nbytes; i++) begin
      exp_q.push_back(fb[i][3:0]);
      exp_q.push_back(fb[i][7:4]);
    end
    len_q.push_back(nbytes);
  endfunction

  // starve >= 0: hold s_valid low for that many payload cycles after byte 0.
  task automatic send_frame(input int n, input int starve, input bit b2b);
    bit abort;
    abort = (starve >= URUN);
    expect_frame(abort ? 1 : n);
    if (abort) exp_urun++;
    else exp_done++;
    for (int i = 0; i < n; i++) begin
      s_data  = fb[i];
      s_last  = (i == n - 1);
      s_valid = 1'b1;
      wait_accept();
      if (i == 0 && starve >= 0) begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        if (abort) begin
          wait_underrun();
          return;
        end
        repeat (starve + 1) @(posedge axi_clk);
        #1;
      end
    end
    if (!b2b) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
    end
  endtask

  task automatic reset_in_pay_hi();
    expect_frame(2);
    s_data  = fb[0];
    s_last  = 1'b0;
    s_valid = 1'b1;
    wait_accept();
    axi_rst = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    @(posedge axi_clk); #1;
    axi_rst = 1'b0;
    exp_q.delete();
    len_q.delete();
    acc_frame = 0;
    gap_slots = 0;
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(posedge axi_clk);
    #1;
    axi_rst = 1'b0;

    ready_mode = 0;
    fb[0] = 8'hA3;
    fb[1] = 8'h5C;
    send_frame(2, -1, 1'b0);
    wait_idle();

    ready_mode = 1;
    fb[0] = 8'h7E;
    send_frame(1, -1, 1'b0);
    wait_idle();

    ready_mode = 0;
    rand_bytes(2);
    send_frame(2, URUN, 1'b0);
    wait_idle();
    ready_mode = 2;
    rand_bytes(3);
    send_frame(3, -1, 1'b0);
    wait_idle();

    ready_mode = 0;
    rand_bytes(2);
    send_frame(2, URUN - 1, 1'b0);
    wait_idle();

    rand_bytes(2);
    reset_in_pay_hi();
    ready_mode = 2;
    rand_bytes(2);
    send_frame(2, -1, 1'b0);
    wait_idle();

    ready_mode = 0;
    for (int f = 0; f < 3; f++) begin
      rand_bytes(int'($urandom_range(1, 4)));
      send_frame(int'($urandom_range(1, 4)), -1, f < 2);
    end
    wait_idle();

    for (int f = 0; f < 20; f++) begin
      int n;
      ready_mode = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 6));
      rand_bytes(n);
      send_frame(n, -1, 1'($urandom_range(0, 1)) && f < 19);
      if (!s_valid) wait_idle();
    end
    wait_idle();

    repeat (5) @(posedge axi_clk);
    #1;
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("underrun_count", 32'(urun_cnt), 32'(exp_urun));
    finish_run();
  end

endmodule
